// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and packed-port slicing helper for the register file
package rf_pkg;
    localparam int DefDataW = 32;
    localparam int DefAddrW = 5;
    localparam logic [DefDataW-1:0] ZeroWord = '0;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register write-pending bits, allocation accept, operand ready and pending count
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W  = DefAddrW,
    parameter int NUM_RD  = 3,
    parameter int NUM_WR  = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     alloc_ok,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD-1:0]        rrdy,
    output logic [ADDR_W:0]          pend_cnt
);
    localparam int Depth = 2 ** ADDR_W;

    logic [Depth-1:0]  pending;
    logic [Depth-1:0]  clr;
    logic [Depth-1:0]  set;
    logic [Depth-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              alloc_zero;
    logic [ADDR_W-1:0] ra [NUM_RD];

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_WR; i++)
            if (wr_en[i]) clr[waddr[slice_lo(i, ADDR_W) +: ADDR_W]] = 1'b1;
        alloc_zero = ZERO_R0 && alloc_addr == '0;
        alloc_ok = !rst && alloc_en && (alloc_zero || !pending[alloc_addr] || clr[alloc_addr]);
        set = '0;
        set[alloc_addr] = alloc_ok && !alloc_zero;
        // set after clear: a same-cycle alloc and write leaves the new producer pending
        pend_nxt = rst ? '0 : (pending & ~clr) | set;
        cnt_nxt = '0;
        for (int a = 0; a < Depth; a++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[a]);
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k] = raddr[slice_lo(k, ADDR_W) +: ADDR_W];
            rrdy[k] = !rst && (!re[k] || (ZERO_R0 && ra[k] == '0) || !pending[ra[k]] || clr[ra[k]]);
        end
    end

    always_ff @(posedge clk) begin
        pending  <= pend_nxt;
        pend_cnt <= cnt_nxt;
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write bypass, fixed write priority and pending scoreboard
module regfile_sb
    import rf_pkg::*;
#(
    parameter int DATA_W  = DefDataW,
    parameter int ADDR_W  = DefAddrW,
    parameter int NUM_RD  = 3,
    parameter int NUM_WR  = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     alloc_ok,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rrdy,
    output logic [ADDR_W:0]          pend_cnt
);
    localparam int Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [Depth];
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] wr_eff;
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [DATA_W-1:0] rd [NUM_RD];

    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            wa[i] = waddr[slice_lo(i, ADDR_W) +: ADDR_W];
            wd[i] = wdata[slice_lo(i, DATA_W) +: DATA_W];
            wr_eff[i] = we[i] && !rst && !(ZERO_R0 && wa[i] == '0);
        end
    end

    // later ports overwrite earlier ones, giving the higher index priority
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < Depth; a++) regs[a] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++)
                if (wr_eff[i]) regs[wa[i]] <= wd[i];
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k] = raddr[slice_lo(k, ADDR_W) +: ADDR_W];
            rd[k] = regs[ra[k]];
            for (int i = 0; i < NUM_WR; i++)
                if (wr_eff[i] && wa[i] == ra[k]) rd[k] = wd[i];
            rdata[slice_lo(k, DATA_W) +: DATA_W] =
                (rst || !re[k] || (ZERO_R0 && ra[k] == '0)) ? DATA_W'(ZeroWord) : rd[k];
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .ZERO_R0(ZERO_R0)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .alloc_ok  (alloc_ok),
        .wr_en     (wr_eff),
        .waddr     (waddr),
        .re        (re),
        .raddr     (raddr),
        .rrdy      (rrdy),
        .pend_cnt  (pend_cnt)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector bench for regfile_sb with hand-computed expectations
module tb_regfile_sb;
    logic        clk;
    logic        rst;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        alloc_ok;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [2:0]  re;
    logic [14:0] raddr;
    logic [95:0] rdata;
    logic [2:0]  rrdy;
    logic [5:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        r;
        logic [1:0]  we;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        ae;
        logic [4:0]  aa;
        logic [2:0]  re;
        logic [4:0]  r0, r1, r2;
        logic [31:0] e0, e1, e2;
        logic [2:0]  rdy;
        logic        aok;
        logic [5:0]  pc;
    } vec_t;

    vec_t tbl [18];

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .alloc_ok  (alloc_ok),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rrdy      (rrdy),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic [1:0] we_, input logic [4:0] a0, a1,
                               input logic [31:0] d0, d1, input logic ae, input logic [4:0] aa,
                               input logic [2:0] re_, input logic [4:0] r0, r1, r2,
                               input logic [31:0] e0, e1, e2, input logic [2:0] rdy,
                               input logic aok, input logic [5:0] pc);
        vec_t t;
        t.r = r; t.we = we_; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.ae = ae; t.aa = aa; t.re = re_; t.r0 = r0; t.r1 = r1; t.r2 = r2;
        t.e0 = e0; t.e1 = e1; t.e2 = e2; t.rdy = rdy; t.aok = aok; t.pc = pc;
        return t;
    endfunction

    task automatic chk(input int id, input string what, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL v%0d %s got %h exp %h", id, what, got, exp);
        end
    endtask

    task automatic run(input vec_t t, input int id);
        @(negedge clk);
        rst = t.r; we = t.we; waddr = {t.a1, t.a0}; wdata = {t.d1, t.d0};
        alloc_en = t.ae; alloc_addr = t.aa; re = t.re; raddr = {t.r2, t.r1, t.r0};
        #1;
        chk(id, "rdata0", rdata[31:0], t.e0);
        chk(id, "rdata1", rdata[63:32], t.e1);
        chk(id, "rdata2", rdata[95:64], t.e2);
        chk(id, "rrdy", {29'd0, rrdy}, {29'd0, t.rdy});
        chk(id, "alloc_ok", {31'd0, alloc_ok}, {31'd0, t.aok});
        chk(id, "pend_cnt", {26'd0, pend_cnt}, {26'd0, t.pc});
    endtask

    initial begin
        rst = 1'b1; we = '0; waddr = '0; wdata = '0; alloc_en = 1'b0; alloc_addr = '0;
        re = '0; raddr = '0;
        // reset held two cycles with writes and allocs active, then basic access
        tbl[0]  = v(1, 2'b11, 5, 6, 'hAA, 'hBB, 1, 3, 3'b111, 5, 6, 3, 0, 0, 0, 3'b000, 0, 0);
        tbl[1]  = v(1, 2'b11, 5, 6, 'hAA, 'hBB, 1, 3, 3'b111, 5, 6, 3, 0, 0, 0, 3'b000, 0, 0);
        tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 5, 6, 3, 0, 0, 0, 3'b111, 0, 0);
        tbl[3]  = v(0, 1, 5, 0, 'hDEADBEEF, 0, 0, 0, 3'b111, 5, 6, 0, 'hDEADBEEF, 0, 0, 3'b111, 0, 0);
        tbl[4]  = v(0, 1, 0, 0, 'h1234, 0, 0, 0, 3'b111, 5, 0, 0, 'hDEADBEEF, 0, 0, 3'b111, 0, 0);
        tbl[5]  = v(0, 3, 7, 7, 'h1111, 'h2222, 0, 0, 3'b111, 7, 0, 5, 'h2222, 0, 'hDEADBEEF, 3'b111, 0, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 7, 0, 0, 'h2222, 0, 0, 3'b111, 0, 0);
        // scoreboard set, WAW stall, write-back bypass and clear
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 1, 9, 3'b111, 9, 7, 0, 0, 'h2222, 0, 3'b111, 1, 0);
        tbl[8]  = v(0, 0, 0, 0, 0, 0, 1, 9, 3'b111, 9, 7, 0, 0, 'h2222, 0, 3'b110, 0, 1);
        tbl[9]  = v(0, 1, 9, 0, 'h42, 0, 0, 0, 3'b111, 9, 9, 7, 'h42, 'h42, 'h2222, 3'b111, 0, 1);
        tbl[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 9, 0, 0, 'h42, 0, 0, 3'b111, 0, 0);
        // alloc and write on the same address in one cycle
        tbl[11] = v(0, 0, 0, 0, 0, 0, 1, 3, 3'b111, 3, 0, 0, 0, 0, 0, 3'b111, 1, 0);
        tbl[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 3, 9, 0, 0, 'h42, 0, 3'b110, 0, 1);
        tbl[13] = v(0, 2, 0, 3, 0, 7, 1, 3, 3'b111, 3, 9, 0, 7, 'h42, 0, 3'b111, 1, 1);
        tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 3, 9, 0, 7, 'h42, 0, 3'b110, 0, 1);
        // alloc of r0 accepted but never pending; disabled read ports
        tbl[15] = v(0, 0, 0, 0, 0, 0, 1, 0, 3'b111, 0, 3, 9, 0, 7, 'h42, 3'b101, 1, 1);
        tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3, 9, 0, 7, 'h42, 3'b101, 0, 1);
        tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 3, 3, 9, 0, 7, 0, 3'b101, 0, 1);
        @(posedge clk);
        for (int i = 0; i < 18; i++) run(tbl[i], i);
        // reset mid-operation with r1, r2, r4 pending
        run(v(0, 1, 3, 0, 5, 0, 1, 1, 3'b111, 1, 2, 4, 0, 0, 0, 3'b111, 1, 1), 100);
        run(v(0, 0, 0, 0, 0, 0, 1, 2, 3'b111, 1, 2, 4, 0, 0, 0, 3'b110, 1, 1), 101);
        run(v(0, 0, 0, 0, 0, 0, 1, 4, 3'b111, 1, 2, 4, 0, 0, 0, 3'b100, 1, 2), 102);
        run(v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 2, 4, 0, 0, 0, 3'b000, 0, 3), 103);
        run(v(1, 1, 6, 0, 'h99, 0, 1, 5, 3'b111, 1, 2, 4, 0, 0, 0, 3'b000, 0, 3), 104);
        run(v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 2, 4, 0, 0, 0, 3'b111, 0, 0), 105);
        run(v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 3, 7, 6, 0, 0, 0, 3'b111, 0, 0), 106);
        run(v(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 9, 5, 5, 0, 0, 0, 3'b111, 0, 0), 107);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with an integrated write-pending scoreboard, for the decode stage of the multi-issue pipeline. It provides NUM_RD read ports with same-cycle write-to-read bypass and NUM_WR write ports with fixed priority. A per-register pending bit is set when the issue logic allocates a destination and cleared when that destination is written back. Decode stalls on the scoreboard instead of on separate hazard logic.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 3, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)
- ZERO_R0, 1, when 1 register 0 reads as zero, ignores writes, never becomes pending
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- alloc_en  in  1  request to mark alloc_addr pending
- alloc_addr  in  ADDR_W  destination being issued
- alloc_ok  out  1  allocation accepted this cycle (combinational)
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, same packing
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses, packed
- rdata  out  NUM_RD*DATA_W  read data, packed (combinational)
- rrdy  out  NUM_RD  per-port operand ready (combinational)
- pend_cnt  out  ADDR_W+1  number of pending registers (registered)

## Operation
- Array: 2**ADDR_W x DATA_W flops; pending: 2**ADDR_W bits.
- Write: at posedge, for each port with we=1 (and waddr!=0 when ZERO_R0), regs[waddr] <= wdata. If two ports hit the same address, the higher port index wins. A write clears pending[waddr]; writing a non-pending register is legal and leaves the scoreboard unchanged.
- Read port k: rdata_k = 0 if rst, re_k=0, or (ZERO_R0 and raddr_k=0). Otherwise it equals wdata of the highest-index write port with we=1 and waddr=raddr_k (bypass). Failing that, it equals regs[raddr_k].
- rrdy_k = 0 during rst. Otherwise it is 1 if re_k=0, raddr_k=0 (ZERO_R0), pending[raddr_k]=0, or a write port hits raddr_k this cycle.
- alloc_ok = !rst and alloc_en, and either pending[alloc_addr]=0 or a write hits alloc_addr this cycle (WAW on an outstanding producer stalls). alloc_addr=0 with ZERO_R0: alloc_ok=1, no bit set.
- Allocate and write to the same address in the same cycle: the write updates data; pending ends set (new producer wins).
- pend_cnt: next-state popcount of pending, registered.

## Timing
- Reset: at the rst posedge, all regs=0, pending=0, pend_cnt=0. While rst=1: rdata=0, rrdy=0, alloc_ok=0, and writes and allocs are ignored. A reset mid-operation discards all pending state in one cycle.
- Read latency 0 (combinational from raddr/re/write ports). The write is visible through bypass in the same cycle and from the array from the next cycle.
- The scoreboard bit is set by an alloc_ok in cycle N and is visible in cycle N+1. A write in cycle N makes rrdy=1 in cycle N (bypass) and clears the bit at the N+1 edge.
- pend_cnt lags the pending vector by 0 cycles (registered alongside it).

## Structure
- Shared package rf_pkg: default DATA_W/ADDR_W, ZeroWord, and the packed-slice helper function for port extraction.
- Sub-module rf_scoreboard: pending vector, alloc_ok, per-port busy lookup, and pend_cnt. The top level holds the array, write priority, and bypass muxes.

## Test plan
- Reset: rst=1 for 2 cycles with we=1 and alloc_en=1 -> rdata=0, rrdy=0, alloc_ok=0; after release all reads return 0 and pend_cnt=0.
- Basic write/read: write r5=0xDEADBEEF on port 0 -> same cycle rdata_0 (raddr=5) = 0xDEADBEEF via bypass; next cycle the same value comes from the array; write r0=0x1234 -> r0 reads 0.
- Write collision: port0 r7=0x1111, port1 r7=0x2222 same cycle -> read r7 = 0x2222 both that cycle and the next.
- Scoreboard: alloc r9 (alloc_ok=1) -> next cycle rrdy for r9 = 0 and pend_cnt=1; second alloc r9 -> alloc_ok=0; write r9=0x42 -> rrdy=1 with rdata=0x42 that cycle; pend_cnt=0 after the edge.
- Alloc and write on same address in one cycle: r3 pending, write r3=0x7 and alloc r3 -> alloc_ok=1, data 0x7, r3 still pending, pend_cnt unchanged.
- Reset mid-operation: pending r1,r2,r4 (pend_cnt=3), assert rst one cycle -> pend_cnt=0, all rrdy=1 after release, contents 0.
